// File: rtl/lc3_mem_arb_pkg.sv
// Shared types for the LC3 unified-memory arbiter.
package lc3_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int unsigned DEFAULT_MEM_LATENCY = 1;
    localparam int unsigned DEFAULT_LAT_CNT_W   = $clog2(DEFAULT_MEM_LATENCY + 1);

    // Latency counter must be able to hold the value MEM_LATENCY itself.
    function automatic int unsigned lat_cnt_w(input int unsigned mem_latency);
        return $clog2(mem_latency + 1);
    endfunction

endpackage

// File: rtl/lc3_mem_arb_pick.sv
// Winner selection between fetch and data, with a streak guard so fetch
// cannot be starved by a continuous run of data requests.
module lc3_mem_arb_pick
    import lc3_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   f_req,
    input  logic   d_req,
    input  logic   arb_en,
    output logic   grant_valid,
    output owner_t grant_owner
);

    localparam int unsigned SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);

    logic [SW-1:0] streak;
    logic          streak_full;

    assign streak_full = (streak == SW'(MAX_DATA_STREAK));

    // Data has priority unless fetch has waited through a full streak.
    always_comb begin
        grant_valid = arb_en && (f_req || d_req);
        if (f_req && d_req) begin
            grant_owner = streak_full ? OWN_FETCH : OWN_DATA;
        end else if (d_req) begin
            grant_owner = OWN_DATA;
        end else begin
            grant_owner = OWN_FETCH;
        end
    end

    // Count data grants made while fetch is waiting; saturate at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (grant_valid) begin
            if (grant_owner == OWN_FETCH || !f_req) begin
                streak <= '0;
            end else if (!streak_full) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one single-port LC3 memory between fetch and memaccess, one
// access at a time, against a fixed-latency memory.
module lc3_mem_arbiter
    import lc3_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = lat_cnt_w(MEM_LATENCY);

    arb_state_t       state;
    owner_t           owner;
    logic [CNT_W-1:0] lat_cnt;
    logic             arb_en;
    logic             grant_valid;
    owner_t           grant_owner;

    assign arb_en = (state == IDLE) || (state == RESP);

    lc3_mem_arb_pick #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_pick (
        .clock      (clock),
        .reset      (reset),
        .f_req      (f_req),
        .d_req      (d_req),
        .arb_en     (arb_en),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    // FSM, latency counter and registered datapath/handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_FETCH;
            lat_cnt   <= '0;
            f_gnt     <= 1'b0;
            f_rvalid  <= 1'b0;
            f_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            f_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            mem_en   <= 1'b0;
            f_rvalid <= 1'b0;
            d_done   <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (grant_valid) begin
                        state     <= ACCESS;
                        owner     <= grant_owner;
                        lat_cnt   <= '0;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        f_gnt     <= (grant_owner == OWN_FETCH);
                        d_gnt     <= (grant_owner == OWN_DATA);
                        mem_we    <= (grant_owner == OWN_DATA) && d_we;
                        mem_addr  <= (grant_owner == OWN_DATA) ? d_addr : f_addr;
                        mem_wdata <= (grant_owner == OWN_DATA) ? d_wdata : '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == CNT_W'(MEM_LATENCY)) begin
                        state <= RESP;
                        if (owner == OWN_FETCH) begin
                            f_rvalid <= 1'b1;
                            f_rdata  <= mem_rdata;
                        end else begin
                            d_done <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
